// File: rtl/tb_pipeline_checker.sv
// Pipeline monitor: learns the latency between idata and odata, then
// checks every output word against the delayed input and counts results.
module tb_pipeline_checker #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_LATENCY = 15,
    parameter int LOCK_CYCLES = 4,
    parameter int CNT_WIDTH   = 16,
    localparam int LAT_W      = $clog2(MAX_LATENCY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic [DATA_WIDTH-1:0] odata,
    output logic                  locked,
    output logic                  timeout,
    output logic [LAT_W-1:0]      latency,
    output logic                  mismatch,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam int SEARCH_LIMIT = 2 * MAX_LATENCY + LOCK_CYCLES;
    localparam int SCNT_W       = $clog2(SEARCH_LIMIT + 1);
    localparam int CONF_W       = $clog2(LOCK_CYCLES + 1);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    logic [1:0]            state;
    logic [LAT_W-1:0]      cand;
    logic [CONF_W-1:0]     conf;
    logic [SCNT_W-1:0]     scnt;

    logic [DATA_WIDTH-1:0] hist_q [1:MAX_LATENCY];
    logic [MAX_LATENCY:1]  vld_q;

    logic [DATA_WIDTH-1:0] hist [0:MAX_LATENCY];
    logic [MAX_LATENCY:0]  vld;
    logic                  hit;
    logic [LAT_W-1:0]      hit_k;
    logic                  cand_ok;
    logic                  lock_ok;
    logic                  search_done;
    logic                  conf_done;

    always_comb begin
        hist[0] = idata;
        for (int k = 1; k <= MAX_LATENCY; k++) begin
            hist[k] = hist_q[k];
        end
        vld = {vld_q, 1'b1};
    end

    // Descending scan so the smallest matching delay is the one kept.
    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        for (int k = MAX_LATENCY; k >= 0; k--) begin
            if (vld[k] && (hist[k] == odata)) begin
                hit   = 1'b1;
                hit_k = LAT_W'(k);
            end
        end
    end

    always_comb begin
        cand_ok     = vld[cand] && (hist[cand] == odata);
        lock_ok     = vld[latency] && (hist[latency] == odata);
        search_done = (32'(scnt) + 32'd1) >= 32'(SEARCH_LIMIT);
        conf_done   = (32'(conf) + 32'd1) >= 32'(LOCK_CYCLES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= MAX_LATENCY; k++) begin
                hist_q[k] <= '0;
            end
            vld_q <= '0;
        end else begin
            hist_q[1] <= idata;
            vld_q[1]  <= 1'b1;
            for (int k = 2; k <= MAX_LATENCY; k++) begin
                hist_q[k] <= hist_q[k-1];
                vld_q[k]  <= vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_SEARCH;
            cand        <= '0;
            conf        <= '0;
            scnt        <= '0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
            latency     <= '0;
            mismatch    <= 1'b0;
            match_count <= '0;
            err_count   <= '0;
        end else begin
            mismatch <= 1'b0;
            unique case (state)
                S_SEARCH: begin
                    if (32'(scnt) < 32'(SEARCH_LIMIT)) begin
                        scnt <= scnt + 1'b1;
                    end
                    if (hit) begin
                        cand <= hit_k;
                        conf <= CONF_W'(1);
                        if (LOCK_CYCLES == 1) begin
                            state   <= S_LOCKED;
                            latency <= hit_k;
                            locked  <= 1'b1;
                        end else begin
                            state <= S_CONFIRM;
                        end
                    end else if (search_done) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                    end
                end
                S_CONFIRM: begin
                    if (cand_ok) begin
                        conf <= conf + 1'b1;
                        if (conf_done) begin
                            state   <= S_LOCKED;
                            latency <= cand;
                            locked  <= 1'b1;
                        end
                    end else begin
                        state <= S_SEARCH;
                        conf  <= '0;
                    end
                end
                S_LOCKED: begin
                    if (lock_ok) begin
                        if (match_count != '1) begin
                            match_count <= match_count + 1'b1;
                        end
                    end else begin
                        mismatch <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                S_TIMEOUT: begin
                    timeout <= 1'b1;
                    locked  <= 1'b0;
                end
                default: state <= S_SEARCH;
            endcase
        end
    end

endmodule

// File: doc/tb_pipeline_checker.md
Name: tb_pipeline_checker

Overview:
Self-checking monitor that sits directly downstream of the pipeline under test in the testbench top. It receives the same stimulus word fed into the pipeline (idata) and the word leaving it (odata), and learns the pipeline latency automatically. After it has locked onto that latency, it checks every output word against the delayed input and keeps match and error statistics. It replaces eyeballing of the per-cycle idata/odata display.

Parameters:
DATA_WIDTH, 8, width of idata/odata
MAX_LATENCY, 15, largest pipeline latency searched (cycles); must be >= 1
LOCK_CYCLES, 4, consecutive matches at one candidate latency needed to lock; must be >= 1
CNT_WIDTH, 16, width of match/error counters
LAT_W, $clog2(MAX_LATENCY+1), derived localparam; width of the latency output

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
idata  in  DATA_WIDTH  stimulus word presented to the pipeline this cycle
odata  in  DATA_WIDTH  word produced by the pipeline this cycle
locked  out  1  latency found; checking active
timeout  out  1  sticky; no lock within search window
latency  out  LAT_W  locked latency (cycles), valid while locked=1
mismatch  out  1  one-cycle pulse, registered, per failed comparison
match_count  out  CNT_WIDTH  saturating count of good comparisons while locked
err_count  out  CNT_WIDTH  saturating count of mismatches while locked

Behaviour:
- History: hist[0] = idata, combinational. hist[1..MAX_LATENCY] form a registered shift line, with hist[k] = idata sampled k edges earlier. Valid bits v[1..MAX_LATENCY] shift in a 1 and clear on reset. hist[0] is always valid. Comparisons only consider valid entries, so reset contents never produce a false match.
- All outputs are registered. Reset value of every output is 0, state is SEARCH, and the history and valid bits clear immediately when rst asserts, with no clock needed.
- Reset asserted mid-operation: everything abandons to reset values, including sticky timeout. Lock is re-learned from scratch after release.
- State machine: SEARCH, CONFIRM, LOCKED, TIMEOUT.
- SEARCH: each edge, find the smallest valid k (0..MAX_LATENCY) with hist[k]==odata.
  - If found: cand<=k, conf<=1, and go to CONFIRM; if LOCK_CYCLES==1, go straight to LOCKED.
  - A search-cycle counter counts edges spent in SEARCH. When it reaches 2*MAX_LATENCY+LOCK_CYCLES without a hit, go to TIMEOUT.
- CONFIRM: each edge, compare hist[cand] (which must be valid) with odata.
  - On a match, conf++. When conf reaches LOCK_CYCLES, go to LOCKED with latency<=cand and locked<=1.
  - On a mismatch, go to SEARCH. conf clears; the search counter is not reset.
- LOCKED: each edge, compare hist[latency] with odata.
  - On a match, match_count++ (saturating at all-ones).
  - On a mismatch, mismatch<=1 for exactly one cycle and err_count++ (saturating).
  - LOCKED is never left except by reset; there is no relock.
  - Counters do not increment in any other state.
- TIMEOUT: timeout=1, locked=0, and the state holds until reset.
- Simultaneous events: in SEARCH, the smallest matching k wins, which makes repeating stimulus deterministic. Counter saturation and mismatch on the same edge: mismatch still pulses and err_count holds at max.
- Latency 0, a pass-through DUT, is legal: locked with latency=0.
- Comparisons use full DATA_WIDTH equality; no masking.
- Wrap-around: data values wrapping (e.g. ff->00) need no special handling because comparison is against history, not increment arithmetic.

Test Plan:
- 3-stage register DUT, counter stimulus from 00, rst released at cycle 0 -> locked=1 with latency=3 on edge 3+LOCK_CYCLES (=7); thereafter match_count increments every cycle, err_count=0, mismatch never high.
- Wire DUT (odata=idata) -> lock with latency=0 after 4 edges; match_count=100 after 100 further edges.
- 3-stage DUT locked, then force odata=8'h5a for one cycle where the expected value is 8'h40 -> mismatch high exactly one cycle, err_count=1, locked stays 1, latency stays 3.
- DUT output stuck at 8'hff with counter stimulus starting at 00 -> the first hit (idata=ff) occurs only after the 2*15+4=34-edge window -> timeout=1 at edge 34, locked=0, both counters 0.
- Locked with err_count=5, assert rst for 1 cycle asynchronously between edges -> all outputs 0 immediately, then relock at latency 3 after release, with counters restarting from 0.
- CNT_WIDTH=4, 20 locked cycles with errors injected at cycles 17-19 -> match_count saturates at 15 and err_count=3; mismatch still pulses on each injected cycle.
